// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-RAM arbiter (mem_arbiter).
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam int MEM_LAT_DEF = 2;

    // Width of the wait-state counter for a given latency: $clog2(lat+1).
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant select between the IF and D request ports.
// On contention the port that was not served last wins; a lone valid
// port is always granted. Tying i_last_owner to OWN_IF gives fixed D priority.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic       i_if_valid,
    input  logic       i_d_valid,
    input  arb_owner_t i_last_owner,
    output arb_owner_t o_owner,
    output logic       o_gnt_valid
);

    // Pick the owner; default to IF so the output is always defined.
    always_comb begin
        o_owner     = OWN_IF;
        o_gnt_valid = i_if_valid | i_d_valid;
        if (i_if_valid && i_d_valid) begin
            o_owner = (i_last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (i_d_valid) begin
            o_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port RAM between instruction fetch (IF) and
// data (D) ports. One access at a time, MEM_LAT cycles of RAM occupancy,
// one response pulse per accepted request.
// Build option: define ARB_ROUND_ROBIN_EN for alternating grant on
// contention; otherwise D has fixed priority.
// Handshake: a request transfers on a rising edge where xx_req_valid and
// xx_req_ready are both high; ready is combinational and only offered in
// IDLE to the granted port. Responses are single-cycle pulses with no
// backpressure. busy exposes the FSM state (high in ACCESS).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              d_req_valid,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int               CNT_W    = cnt_width(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    arb_owner_t        r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_if_rsp_valid;
    logic [DATA_W-1:0] r_if_rsp_data;
    logic              r_d_rsp_valid;
    logic [DATA_W-1:0] r_d_rsp_data;

    arb_owner_t        w_gnt_owner;
    arb_owner_t        w_last_owner;
    logic              w_gnt_valid;
    logic              w_idle;
    logic              w_hs;
    logic              w_first_cycle;
    logic              w_last_cycle;

    mem_arb_grant u_grant (
        .i_if_valid   (if_req_valid),
        .i_d_valid    (d_req_valid),
        .i_last_owner (w_last_owner),
        .o_owner      (w_gnt_owner),
        .o_gnt_valid  (w_gnt_valid)
    );

    // No request may be accepted while reset is held, so ready is gated by it.
    assign w_idle        = reset && (r_state == ST_IDLE);
    assign if_req_ready  = w_idle && if_req_valid && w_gnt_valid && (w_gnt_owner == OWN_IF);
    assign d_req_ready   = w_idle && d_req_valid && w_gnt_valid && (w_gnt_owner == OWN_D);
    assign w_hs          = if_req_ready || d_req_ready;
    assign w_first_cycle = (r_state == ST_ACCESS) && (r_cnt == CNT_LOAD);
    assign w_last_cycle  = (r_state == ST_ACCESS) && (r_cnt == '0);

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t r_last_owner;

    // Remember who was served last; IF after reset so D wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_owner <= OWN_IF;
        end else if (w_hs) begin
            r_last_owner <= w_gnt_owner;
        end
    end

    assign w_last_owner = r_last_owner;
`else
    // Pretending IF was always served last makes D win every tie.
    assign w_last_owner = OWN_IF;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave IDLE on a handshake, leave ACCESS when the wait ends.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_hs)         w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_last_cycle) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the accepted request and run the wait-state counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_hs) begin
            r_cnt   <= CNT_LOAD;
            r_owner <= w_gnt_owner;
            if (w_gnt_owner == OWN_D) begin
                r_addr  <= d_req_addr;
                r_we    <= d_req_we;
                r_wdata <= d_req_wdata;
            end else begin
                r_addr  <= if_req_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
            end
        end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Capture read data on the last ACCESS cycle and pulse the owner's valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
            r_d_rsp_valid  <= 1'b0;
            r_d_rsp_data   <= '0;
        end else begin
            r_if_rsp_valid <= 1'b0;
            r_d_rsp_valid  <= 1'b0;
            if (w_last_cycle) begin
                if (r_owner == OWN_D) begin
                    r_d_rsp_valid <= 1'b1;
                    r_d_rsp_data  <= r_we ? '0 : mem_rdata;
                end else begin
                    r_if_rsp_valid <= 1'b1;
                    r_if_rsp_data  <= mem_rdata;
                end
            end
        end
    end

    assign if_rsp_valid = r_if_rsp_valid;
    assign if_rsp_data  = r_if_rsp_data;
    assign d_rsp_valid  = r_d_rsp_valid;
    assign d_rsp_data   = r_d_rsp_data;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_we       = w_first_cycle && r_we;
    assign busy         = (r_state == ST_ACCESS);

endmodule
